// File: rtl/mem_stage.sv
// mem_stage: RV32I memory stage issuing loads/stores over a req/resp port and registering the MEM/WB record.
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   in_*                         EX/MEM pipeline register contents
//   dmem_read/write/addr/wmask/wdata  data-memory request, held stable while BUSY
//   dmem_rdata, dmem_resp        data-memory response (resp is a one-cycle pulse)
//   stall                        combinational freeze of EX/MEM and upstream
//   wb_*                         registered write-back record
module mem_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic            in_mem_read,
    input  logic            in_mem_write,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_store_data,
    input  logic [REGW-1:0] in_rd,
    input  logic            in_rd_wen,
    output logic            dmem_read,
    output logic            dmem_write,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_wmask,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_resp,
    output logic            stall,
    output logic            wb_valid,
    output logic [REGW-1:0] wb_rd,
    output logic            wb_wen,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_misaligned
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state_q, state_d;
    logic rd_q, rd_d, wr_q, wr_d, wen_q, wen_d;
    logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0] mask_q, mask_d;
    logic [2:0] f3_q, f3_d;
    logic [REGW-1:0] rdi_q, rdi_d;
    logic wb_valid_q, wb_valid_d, wb_wen_q, wb_wen_d, wb_mis_q, wb_mis_d;
    logic [REGW-1:0] wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic is_mem, byte_sz, half_sz, misal;
    logic [1:0] off;
    logic [3:0] smask;
    logic [XLEN-1:0] sdata, lane, ld_data;
    // funct3[1:0]: 00 byte, 01 half, anything else is word-sized
    assign is_mem  = in_valid & (in_mem_read | in_mem_write);
    assign off     = in_alu_result[1:0];
    assign byte_sz = in_funct3[1:0] == 2'b00;
    assign half_sz = in_funct3[1:0] == 2'b01;
    assign misal   = half_sz ? off[0] : !byte_sz && off != 2'b00;
    assign smask   = byte_sz ? 4'b0001 << off : half_sz ? 4'b0011 << off : 4'b1111;
    assign sdata   = byte_sz ? {4{in_store_data[7:0]}} : half_sz ? {2{in_store_data[15:0]}} : in_store_data;
    // funct3[2] set means unsigned load
    assign lane    = dmem_rdata >> {addr_q[1:0], 3'b000};
    assign ld_data = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & lane[7]}}, lane[7:0]} :
                     f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & lane[15]}}, lane[15:0]} : dmem_rdata;
    always_comb begin
        state_d    = state_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        mask_d     = mask_q;
        wdata_d    = wdata_q;
        f3_d       = f3_q;
        rdi_d      = rdi_q;
        wen_d      = wen_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_wen_d   = wb_wen_q;
        wb_data_d  = wb_data_q;
        wb_mis_d   = wb_mis_q;
        stall      = 1'b0;
        if (state_q == IDLE) begin
            if (is_mem && !misal) begin
                stall   = 1'b1;
                state_d = BUSY;
                // read wins if both flags are set so read/write never overlap
                rd_d    = in_mem_read;
                wr_d    = !in_mem_read;
                addr_d  = in_alu_result;
                mask_d  = in_mem_read ? 4'b0000 : smask;
                wdata_d = in_mem_read ? '0 : sdata;
                f3_d    = in_funct3;
                rdi_d   = in_rd;
                wen_d   = in_rd_wen & in_mem_read;
            end else if (in_valid) begin
                wb_valid_d = 1'b1;
                wb_rd_d    = in_rd;
                wb_wen_d   = in_rd_wen & !is_mem;
                wb_data_d  = in_alu_result;
                wb_mis_d   = is_mem;
            end
        end else begin
            stall = !dmem_resp;
            if (dmem_resp) begin
                state_d    = IDLE;
                rd_d       = 1'b0;
                wr_d       = 1'b0;
                addr_d     = '0;
                mask_d     = 4'b0000;
                wdata_d    = '0;
                wb_valid_d = 1'b1;
                wb_rd_d    = rdi_q;
                wb_wen_d   = wen_q;
                wb_data_d  = rd_q ? ld_data : addr_q;
                wb_mis_d   = 1'b0;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            mask_q     <= 4'b0000;
            wdata_q    <= '0;
            f3_q       <= 3'b000;
            rdi_q      <= '0;
            wen_q      <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_wen_q   <= 1'b0;
            wb_data_q  <= '0;
            wb_mis_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            mask_q     <= mask_d;
            wdata_q    <= wdata_d;
            f3_q       <= f3_d;
            rdi_q      <= rdi_d;
            wen_q      <= wen_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_wen_q   <= wb_wen_d;
            wb_data_q  <= wb_data_d;
            wb_mis_q   <= wb_mis_d;
        end
    end
    assign dmem_read     = rd_q;
    assign dmem_write    = wr_q;
    assign dmem_addr     = {addr_q[XLEN-1:2], 2'b00};
    assign dmem_wmask    = mask_q;
    assign dmem_wdata    = wdata_q;
    assign wb_valid      = wb_valid_q;
    assign wb_rd         = wb_rd_q;
    assign wb_wen        = wb_wen_q;
    assign wb_data       = wb_data_q;
    assign wb_misaligned = wb_mis_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_mem_read, in_mem_write, in_rd_wen;
    logic [2:0]  in_funct3;
    logic [31:0] in_alu_result, in_store_data;
    logic [4:0]  in_rd;
    logic        dmem_read, dmem_write, dmem_resp, stall;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wmask;
    logic        wb_valid, wb_wen, wb_misaligned;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    int n_cmp = 0;
    int n_err = 0;

    mem_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .in_funct3(in_funct3), .in_alu_result(in_alu_result), .in_store_data(in_store_data),
        .in_rd(in_rd), .in_rd_wen(in_rd_wen),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_addr(dmem_addr),
        .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_resp(dmem_resp), .stall(stall),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_wen(wb_wen), .wb_data(wb_data),
        .wb_misaligned(wb_misaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic r, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd,
                         input logic wen);
        in_valid = v; in_mem_read = r; in_mem_write = w; in_funct3 = f3;
        in_alu_result = a; in_store_data = sd; in_rd = rd; in_rd_wen = wen;
        #1;
    endtask

    task automatic bubble();
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    endtask

    // Full aligned access: issue, `waits` busy cycles, resp cycle, then the wb record.
    task automatic mem_op(input string tag, input logic r, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdata,
                          input int waits, input logic [31:0] e_addr, input logic [3:0] e_mask,
                          input logic [31:0] e_wdata, input logic [31:0] e_wb);
        step();
        drive(1'b1, r, !r, f3, a, sd, 5'd3, 1'b1);
        chk({tag, "_issue_stall"}, 32'(stall), 32'd1);
        for (int i = 0; i < waits; i++) begin
            step();
            chk({tag, "_busy_stall"}, 32'(stall), 32'd1);
            chk({tag, "_rd"}, 32'(dmem_read), 32'(r));
            chk({tag, "_wr"}, 32'(dmem_write), 32'(!r));
            chk({tag, "_addr"}, dmem_addr, e_addr);
            chk({tag, "_mask"}, 32'(dmem_wmask), 32'(e_mask));
            if (!r) chk({tag, "_wdata"}, dmem_wdata, e_wdata);
        end
        step();
        dmem_resp = 1'b1; dmem_rdata = rdata;
        #1;
        chk({tag, "_resp_stall"}, 32'(stall), 32'd0);
        chk({tag, "_resp_addr"}, dmem_addr, e_addr);
        step();
        dmem_resp = 1'b0; dmem_rdata = 32'h0;
        bubble();
        chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd1);
        chk({tag, "_wb_rd"}, 32'(wb_rd), 32'd3);
        chk({tag, "_wb_wen"}, 32'(wb_wen), 32'(r));
        chk({tag, "_wb_mis"}, 32'(wb_misaligned), 32'd0);
        if (r) chk({tag, "_wb_data"}, wb_data, e_wb);
        chk({tag, "_req_clear"}, 32'({dmem_read, dmem_write}), 32'd0);
        step();
        chk({tag, "_wb_drop"}, 32'(wb_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; dmem_resp = 1'b0; dmem_rdata = 32'h0;
        bubble();
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_req", 32'({dmem_read, dmem_write}), 32'd0);
        chk("rst_addr", dmem_addr, 32'h0);
        chk("rst_mask", 32'(dmem_wmask), 32'h0);
        chk("rst_wdata", dmem_wdata, 32'h0);
        chk("rst_wb", 32'({wb_valid, wb_wen, wb_misaligned}), 32'd0);
        chk("rst_wb_data", wb_data, 32'h0);
        chk("rst_stall", 32'(stall), 32'd0);

        mem_op("lw",  1'b1, 3'b010, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 2, 32'h1004, 4'b0000, 32'h0, 32'hDEAD_BEEF);
        mem_op("lb",  1'b1, 3'b000, 32'h0000_2003, 32'h0, 32'h80FF_FFFF, 1, 32'h2000, 4'b0000, 32'h0, 32'hFFFF_FF80);
        mem_op("lbu", 1'b1, 3'b100, 32'h0000_2003, 32'h0, 32'h80FF_FFFF, 1, 32'h2000, 4'b0000, 32'h0, 32'h0000_0080);
        mem_op("lh",  1'b1, 3'b001, 32'h0000_7002, 32'h0, 32'h8001_1234, 0, 32'h7000, 4'b0000, 32'h0, 32'hFFFF_8001);
        mem_op("lhu", 1'b1, 3'b101, 32'h0000_7002, 32'h0, 32'h8001_1234, 1, 32'h7000, 4'b0000, 32'h0, 32'h0000_8001);
        mem_op("sh",  1'b0, 3'b001, 32'h0000_3002, 32'h1234_ABCD, 32'h0, 1, 32'h3000, 4'b1100, 32'hABCD_ABCD, 32'h0);
        mem_op("sb",  1'b0, 3'b000, 32'h0000_6001, 32'h0000_00AB, 32'h0, 1, 32'h6000, 4'b0010, 32'hABAB_ABAB, 32'h0);
        mem_op("sw",  1'b0, 3'b010, 32'h0000_5008, 32'hCAFE_F00D, 32'h0, 1, 32'h5008, 4'b1111, 32'hCAFE_F00D, 32'h0);

        step();
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_1001, 32'h0, 5'd4, 1'b1);
        chk("mis_stall", 32'(stall), 32'd0);
        step();
        bubble();
        chk("mis_req", 32'({dmem_read, dmem_write}), 32'd0);
        chk("mis_valid", 32'(wb_valid), 32'd1);
        chk("mis_wen", 32'(wb_wen), 32'd0);
        chk("mis_flag", 32'(wb_misaligned), 32'd1);
        chk("mis_data", wb_data, 32'h0000_1001);

        step();
        drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_0055, 32'h0, 5'd7, 1'b1);
        chk("add_stall", 32'(stall), 32'd0);
        step();
        bubble();
        chk("add_valid", 32'(wb_valid), 32'd1);
        chk("add_rd", 32'(wb_rd), 32'd7);
        chk("add_wen", 32'(wb_wen), 32'd1);
        chk("add_data", wb_data, 32'h55);
        chk("add_mis", 32'(wb_misaligned), 32'd0);
        step();
        chk("bubble_valid", 32'(wb_valid), 32'd0);

        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'h0, 5'd9, 1'b1);
        step();
        chk("rstb_busy", 32'(dmem_read), 32'd1);
        rst = 1'b1;
        bubble();
        step();
        rst = 1'b0;
        dmem_resp = 1'b1; dmem_rdata = 32'h1111_2222;
        #1;
        chk("rstb_req", 32'({dmem_read, dmem_write}), 32'd0);
        chk("rstb_addr", dmem_addr, 32'h0);
        chk("rstb_wb", 32'({wb_valid, wb_wen, wb_misaligned}), 32'd0);
        chk("rstb_stall", 32'(stall), 32'd0);
        step();
        dmem_resp = 1'b0;
        #1;
        chk("late_resp_valid", 32'(wb_valid), 32'd0);
        chk("late_resp_data", wb_data, 32'h0);
        chk("late_resp_req", 32'({dmem_read, dmem_write}), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the RV32I 5-stage pipeline.
- Consumes the EX/MEM pipeline register output and issues loads and stores to the data-memory port with a req/resp handshake.
- Aligns and sign- or zero-extends load data, then produces the registered write-back record for the MEM/WB boundary.
- Asserts stall while a memory access is outstanding, so the EX/MEM register and earlier stages freeze.

Parameters:
XLEN, 32, datapath and address width (only 32 supported)
REGW, 5, register-file index width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  EX/MEM holds a live instruction (0 = bubble)
in_mem_read  in  1  instruction is a load
in_mem_write  in  1  instruction is a store
in_funct3  in  3  load/store size/sign encoding
in_alu_result  in  XLEN  effective address (mem ops) or ALU result
in_store_data  in  XLEN  rs2 value for stores
in_rd  in  REGW  destination register
in_rd_wen  in  1  instruction writes rd
dmem_read  out  1  read request
dmem_write  out  1  write request
dmem_addr  out  XLEN  word-aligned address ({addr[31:2],2'b00})
dmem_wmask  out  4  byte-lane write enables
dmem_wdata  out  XLEN  lane-positioned store data
dmem_rdata  in  XLEN  read data, valid with dmem_resp
dmem_resp  in  1  access complete (one-cycle pulse)
stall  out  1  freeze EX/MEM and upstream; combinational
wb_valid  out  1  wb record valid this cycle
wb_rd  out  REGW  destination register
wb_wen  out  1  register write enable
wb_data  out  XLEN  write-back value
wb_misaligned  out  1  instruction retired with a misaligned address

Behaviour:
- Reset: state=IDLE; dmem_read=dmem_write=0; dmem_addr, dmem_wmask, dmem_wdata=0; all wb_* outputs=0.
- Reset mid-access abandons the request. A late dmem_resp arriving after reset is ignored, because it is only honoured in BUSY.
- FSM states: IDLE, BUSY.
- Misalignment: a halfword access with addr[0]=1, or a word access with addr[1:0]!=0.
- IDLE, input is a mem op (in_valid & (read|write)) and aligned:
  - latch request registers; go to BUSY next edge.
  - stall=1 combinationally in this cycle.
  - wb_valid<=0.
- IDLE, input valid and not a mem op:
  - wb_valid<=1, wb_data<=in_alu_result, wb_rd/wb_wen<=inputs, wb_misaligned<=0.
  - Latency 1 cycle; stall=0.
- IDLE, input is a misaligned mem op:
  - no dmem request is issued; stall=0.
  - wb_valid<=1, wb_wen<=0, wb_misaligned<=1, wb_data<=in_alu_result.
- IDLE with a bubble: wb_valid<=0.
- BUSY:
  - dmem_read or dmem_write, dmem_addr, dmem_wmask and dmem_wdata are held stable until dmem_resp.
  - stall=1 until the dmem_resp cycle. In the resp cycle stall=0, so EX/MEM advances at that edge.
  - On dmem_resp: state<=IDLE; request outputs<=0; wb_valid<=1; wb_rd/wb_wen from the latched request.
  - Load: wb_data<=extended lane data. Store: wb_wen<=0.
  - Without resp: wb_valid<=0.
- Store mask: SB (000): 4'b0001<<off. SH (001): 4'b0011<<off. SW (010): 4'b1111. Here off=addr[1:0].
- Store data is replicated per lane:
  - SB: {4{rs2[7:0]}}
  - SH: {2{rs2[15:0]}}
  - SW: rs2 unchanged
- Loads: dmem_wmask=0. The byte or halfword is selected by off from dmem_rdata.
  - LB (000) and LH (001) sign-extend.
  - LBU (100) and LHU (101) zero-extend.
  - LW (010) passes the word through.
- Other funct3 encodings are treated as word size.
- Every instruction presented while not stalled retires exactly once. No duplicate capture occurs in the cycle after a resp.
- dmem_read and dmem_write are never asserted together.

Test Plan:
- LW at addr 0x0000_1004, resp after 3 cycles with rdata 0xDEADBEEF -> dmem_read=1 and addr=0x1004 held stable; stall=1 for 3 cycles, 0 in the resp cycle; next cycle wb_valid=1, wb_data=0xDEADBEEF.
- LB at 0x2003, rdata 0x80FF_FFFF -> wb_data=0xFFFF_FF80. LBU with the same stimulus -> wb_data=0x0000_0080.
- SH at 0x3002, rs2=0x1234_ABCD -> dmem_write=1, wmask=4'b1100, wdata=0xABCD_ABCD, addr=0x3000; on resp wb_wen=0.
- LW at 0x1001 -> no dmem request, stall=0; next cycle wb_valid=1, wb_wen=0, wb_misaligned=1.
- ADD result 0x55 to rd=7 followed by a bubble -> wb_valid=1, wb_rd=7, wb_data=0x55 one cycle later; then wb_valid=0.
- rst asserted while in BUSY (no resp yet), then resp pulses after reset -> next cycle all outputs 0, state IDLE, the late resp is ignored, no wb_valid.
